// File: rtl/tone_period_meter.sv
// tone_period_meter
//   Measures the period of an external square wave in clk cycles. The raw
//   input is synchronised, rising edges are detected, and edges that come too
//   soon after the previous accepted edge are counted as glitches. Each
//   accepted period is reported with a one-cycle strobe. The block also flags
//   a stable tone (two consecutive periods within tolerance) and silence (no
//   accepted edge for a full counter span).
//
// Ports
//   clk           system clock
//   reset         asynchronous, active-high reset
//   audio_in      raw asynchronous square wave
//   period        last accepted period in clk cycles
//   period_valid  one-cycle strobe when period updates
//   locked        last two periods differ by no more than lock_tolerance
//   silence       no accepted edge for 2^period_width - 1 cycles
//   glitch_count  rejected edges, saturating at 255
module tone_period_meter #(
    parameter int period_width   = 20,
    parameter int min_period     = 16,
    parameter int lock_tolerance = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    audio_in,
    output logic [period_width-1:0] period,
    output logic                    period_valid,
    output logic                    locked,
    output logic                    silence,
    output logic [7:0]              glitch_count
);

    localparam int W = period_width;
    localparam logic [W-1:0] CNT_MAX = '1;
    localparam logic [W-1:0] MIN_P   = W'(min_period);
    localparam logic [W-1:0] TOL     = W'(lock_tolerance);
    localparam logic [W-1:0] CNT_ONE = W'(1);

    typedef enum logic {S_WAIT_FIRST, S_MEASURE} state_t;

    state_t state, state_nxt;

    logic         sync1, sync2, prev;
    logic         rise;
    logic [W-1:0] cnt;
    logic [W-1:0] diff;
    logic         in_tol;
    logic         have_prev;   // a period was accepted since entering S_MEASURE

    // FSM decode strobes
    logic first_rise, accept, reject, timeout;

    // ------------------------------------------------------------------
    // Input path: two-flop synchroniser plus a previous-value flop
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= audio_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise = sync2 & ~prev;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_WAIT_FIRST;
        else       state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            S_WAIT_FIRST: if (rise) state_nxt = S_MEASURE;
            // A rise on the terminal count wins over the timeout.
            S_MEASURE:    if (!rise && cnt == CNT_MAX) state_nxt = S_WAIT_FIRST;
            default:      state_nxt = S_WAIT_FIRST;
        endcase
    end

    // FSM: outputs (decode strobes consumed by the datapath)
    always_comb begin
        first_rise = 1'b0;
        accept     = 1'b0;
        reject     = 1'b0;
        timeout    = 1'b0;
        case (state)
            S_WAIT_FIRST: first_rise = rise;
            S_MEASURE: begin
                accept  = rise && (cnt >= MIN_P);
                reject  = rise && (cnt <  MIN_P);
                timeout = !rise && (cnt == CNT_MAX);
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Lock comparison: unsigned |cnt - period|, larger minus smaller
    // ------------------------------------------------------------------
    always_comb begin
        diff   = (cnt > period) ? (cnt - period) : (period - cnt);
        in_tol = (diff <= TOL);
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            silence      <= 1'b0;
            glitch_count <= 8'd0;
            have_prev    <= 1'b0;
        end else begin
            period_valid <= accept;

            // The accepted rise itself counts as cycle 1 of the next period.
            // cnt is held in S_WAIT_FIRST and on the timeout cycle.
            if (first_rise || accept)
                cnt <= CNT_ONE;
            else if (state == S_MEASURE && !timeout)
                cnt <= cnt + CNT_ONE;

            if (accept)
                period <= cnt;

            if (accept)
                locked <= have_prev && in_tol;
            else if (timeout)
                locked <= 1'b0;

            // Lock needs two periods after every (re)entry to S_MEASURE.
            if (first_rise)
                have_prev <= 1'b0;
            else if (accept)
                have_prev <= 1'b1;

            if (timeout)
                silence <= 1'b1;
            else if (first_rise)
                silence <= 1'b0;

            if (reject && glitch_count != 8'hFF)
                glitch_count <= glitch_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_tone_period_meter.sv
// Bench for tone_period_meter: directed square-wave vectors on two instances,
// one with the default 20-bit counter and one with an 8-bit counter for the
// silence timeout.
module tb_tone_period_meter;

    logic        clk = 1'b0;
    logic        reset;
    logic        audio_a, audio_b;
    logic [19:0] period_a;
    logic [7:0]  period_b;
    logic        pv_a, pv_b, locked_a, locked_b, silence_a, silence_b;
    logic [7:0]  glitch_a, glitch_b;

    int nchk = 0;
    int nerr = 0;
    int pa = 0, pb = 0;     // strobe counts per instance
    int dbl = 0;            // strobes wider than one cycle
    logic pv_a_d = 1'b0, pv_b_d = 1'b0;
    int base;

    always #5 clk = ~clk;

    tone_period_meter dut_a (
        .clk(clk), .reset(reset), .audio_in(audio_a),
        .period(period_a), .period_valid(pv_a), .locked(locked_a),
        .silence(silence_a), .glitch_count(glitch_a)
    );

    tone_period_meter #(.period_width(8)) dut_b (
        .clk(clk), .reset(reset), .audio_in(audio_b),
        .period(period_b), .period_valid(pv_b), .locked(locked_b),
        .silence(silence_b), .glitch_count(glitch_b)
    );

    // Strobe monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (pv_a) begin pa = pa + 1; if (pv_a_d) dbl = dbl + 1; end
        if (pv_b) begin pb = pb + 1; if (pv_b_d) dbl = dbl + 1; end
        pv_a_d = pv_a;
        pv_b_d = pv_b;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk = nchk + 1;
        if (got !== exp) begin
            nerr = nerr + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input int sel, input logic v);
        if (sel == 0) audio_a = v;
        else          audio_b = v;
    endtask

    // One period: high for hi cycles then low for lo cycles (rise at start).
    task automatic tone(input int sel, input int hi, input int lo);
        drive(sel, 1'b1); cyc(hi);
        drive(sel, 1'b0); cyc(lo);
    endtask

    // 100-cycle period with a 2-cycle dip 5 cycles after the rise, which
    // creates a spurious rise about 7 cycles into the period.
    task automatic glitch_tone();
        drive(0, 1'b1); cyc(5);
        drive(0, 1'b0); cyc(2);
        drive(0, 1'b1); cyc(43);
        drive(0, 1'b0); cyc(50);
    endtask

    initial begin
        reset   = 1'b1;
        audio_a = 1'b0;
        audio_b = 1'b0;
        cyc(3);
        chk("rst_period",  period_a,  0);
        chk("rst_valid",   pv_a,      0);
        chk("rst_locked",  locked_a,  0);
        chk("rst_silence", silence_a, 0);
        chk("rst_glitch",  glitch_a,  0);
        reset = 1'b0;

        // Idle input after reset release
        cyc(100);
        chk("idle_strobes", pa,        0);
        chk("idle_period",  period_a,  0);
        chk("idle_locked",  locked_a,  0);
        chk("idle_silence", silence_a, 0);
        chk("idle_glitch",  glitch_a,  0);

        // Steady 100-cycle wave, five rises
        tone(0, 50, 50);
        chk("sq_first_nostrobe", pa, 0);
        tone(0, 50, 50);
        chk("sq_r2_strobes", pa, 1);
        chk("sq_r2_period",  period_a, 100);
        chk("sq_r2_locked",  locked_a, 0);
        tone(0, 50, 50);
        chk("sq_r3_locked",  locked_a, 1);
        tone(0, 50, 50);
        tone(0, 50, 50);
        chk("sq_strobes", pa, 4);
        chk("sq_period",  period_a, 100);
        chk("sq_locked",  locked_a, 1);

        // Periods 100, 103, 110
        tone(0, 50, 53);
        chk("p100_period", period_a, 100);
        tone(0, 50, 60);
        chk("p103_period", period_a, 103);
        chk("p103_locked", locked_a, 1);
        tone(0, 50, 50);
        chk("p110_period", period_a, 110);
        chk("p110_locked", locked_a, 0);

        // Re-lock, then inject one glitch
        tone(0, 50, 50);
        tone(0, 50, 50);
        chk("relock", locked_a, 1);
        glitch_tone();
        chk("gl_count1", glitch_a, 1);
        base = pa;
        tone(0, 50, 50);
        chk("gl_period", period_a, 100);
        chk("gl_strobe", pa - base, 1);
        chk("gl_locked", locked_a, 1);

        // Saturation after 300 glitches in total
        for (int i = 0; i < 299; i++) glitch_tone();
        chk("gl_sat",        glitch_a, 255);
        chk("gl_sat_locked", locked_a, 1);

        // 8-bit instance: one rise, then held low until the timeout
        tone(1, 50, 200);
        chk("b_pre_silence", silence_b, 0);
        cyc(15);
        chk("b_silence",  silence_b, 1);
        chk("b_locked",   locked_b,  0);
        chk("b_nostrobe", pb,        0);
        tone(1, 50, 50);
        chk("b_silence_clr", silence_b, 0);
        chk("b_first_after", pb,        0);
        tone(1, 50, 50);
        chk("b_strobe", pb,       1);
        chk("b_period", period_b, 100);
        chk("b_locked2", locked_b, 0);

        // Asynchronous reset mid-period while locked
        chk("pre_rst_locked", locked_a, 1);
        drive(0, 1'b1);
        cyc(30);
        reset = 1'b1;
        #1;
        chk("arst_period",  period_a,  0);
        chk("arst_valid",   pv_a,      0);
        chk("arst_locked",  locked_a,  0);
        chk("arst_silence", silence_a, 0);
        chk("arst_glitch",  glitch_a,  0);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 1'b0);
        cyc(20);
        base = pa;
        tone(0, 50, 50);
        chk("post_rst_nostrobe", pa - base, 0);
        chk("post_rst_locked",   locked_a,  0);
        tone(0, 50, 50);
        chk("post_rst_strobe", pa - base, 1);
        chk("post_rst_period", period_a,  100);

        chk("strobe_width", dbl, 0);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nerr);
        $finish;
    end

endmodule
